// File: rtl/agc_loop_sequencer_if.sv
// Wishbone master/slave bundle between the AGC loop sequencer
// and one channel's AGC register block.
interface agc_loop_sequencer_if;
    logic        m_wb_cyc_o;
    logic        m_wb_stb_o;
    logic        m_wb_we_o;
    logic [7:0]  m_wb_adr_o;
    logic [31:0] m_wb_dat_o;
    logic [3:0]  m_wb_sel_o;
    logic [31:0] m_wb_dat_i;
    logic        m_wb_ack_i;
    logic        m_wb_err_i;

    modport master (
        output m_wb_cyc_o, m_wb_stb_o, m_wb_we_o,
        output m_wb_adr_o, m_wb_dat_o, m_wb_sel_o,
        input  m_wb_dat_i, m_wb_ack_i, m_wb_err_i
    );

    modport slave (
        input  m_wb_cyc_o, m_wb_stb_o, m_wb_we_o,
        input  m_wb_adr_o, m_wb_dat_o, m_wb_sel_o,
        output m_wb_dat_i, m_wb_ack_i, m_wb_err_i
    );
endinterface

// File: rtl/agc_loop_sequencer.sv
// Autonomous Wishbone master closing the AGC gain/offset loop:
// init, then tick / poll / read accumulators / adjust / load per iteration.
module agc_loop_sequencer #(
    parameter int POLL_LIMIT = 1024,
    parameter int ITER_BITS  = 8
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 start_i,
    input  logic                 stop_i,
    input  logic [ITER_BITS-1:0] iterations_i,
    input  logic [24:0]          target_sq_i,
    input  logic [24:0]          sq_tol_i,
    input  logic [20:0]          ofs_tol_i,
    input  logic [16:0]          scale_step_i,
    input  logic [15:0]          offset_step_i,
    input  logic [16:0]          init_scale_i,
    input  logic [15:0]          init_offset_i,
    agc_loop_sequencer_if.master m_wb,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 converged_o,
    output logic                 error_o,
    output logic [16:0]          scale_o,
    output logic [15:0]          offset_o,
    output logic [ITER_BITS-1:0] iter_o
);
    localparam int PW = $clog2(POLL_LIMIT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_INIT_RST, S_INIT_SC, S_INIT_OF, S_INIT_LD,
        S_TICK, S_POLL, S_RD_SQ, S_RD_GT, S_RD_LT, S_CALC,
        S_WR_SC, S_WR_OF, S_WR_LD, S_FINISH
    } state_t;

    state_t r_state, w_nxt;

    logic                 r_gap, r_stop_pend, r_conv, r_converged, r_error;
    logic [PW-1:0]        r_poll;
    logic [24:0]          r_sq;
    logic [20:0]          r_gt, r_lt;
    logic [16:0]          r_scale;
    logic [15:0]          r_offset;
    logic [ITER_BITS-1:0] r_iter;

    logic                 w_bus_st, w_cyc, w_ack, w_err, w_xfer_end;
    logic                 w_halt, w_done_bit, w_timeout;
    logic [PW-1:0]        w_poll_nxt;
    logic [ITER_BITS-1:0] w_iter_nxt;
    logic                 w_we;
    logic [7:0]           w_adr;
    logic [31:0]          w_dat;

    // r_gap forces the mandatory idle bus cycle after every response
    assign w_bus_st   = !(r_state inside {S_IDLE, S_CALC, S_FINISH});
    assign w_cyc      = w_bus_st && !r_gap;
    assign w_ack      = w_cyc && m_wb.m_wb_ack_i;
    assign w_err      = w_cyc && m_wb.m_wb_err_i;
    assign w_xfer_end = w_ack || w_err;
    assign w_halt     = (stop_i || r_stop_pend) && (!w_cyc || w_xfer_end)
                        && (r_state != S_FINISH);
    assign w_done_bit = m_wb.m_wb_dat_i[1];
    assign w_poll_nxt = r_poll + 1'b1;
    assign w_timeout  = (r_state == S_POLL) && w_ack && !w_done_bit
                        && (w_poll_nxt == PW'(POLL_LIMIT));
    assign w_iter_nxt = r_iter + 1'b1;

    logic [25:0]        w_sq_hi;
    logic               w_sc_dn, w_sc_up;
    logic [17:0]        w_sc_sum;
    logic [16:0]        w_sc_new;
    logic signed [21:0] w_diff, w_tol;
    logic               w_of_dn, w_of_up;
    logic signed [17:0] w_of_ext, w_of_stp, w_of_sum, w_of_dif;
    logic [15:0]        w_of_new;

    assign w_sq_hi  = {1'b0, target_sq_i} + {1'b0, sq_tol_i};
    assign w_sc_dn  = {1'b0, r_sq} > w_sq_hi;
    assign w_sc_up  = (sq_tol_i <= target_sq_i)
                      && (r_sq < target_sq_i - sq_tol_i);
    assign w_sc_sum = {1'b0, r_scale} + {1'b0, scale_step_i};
    assign w_diff   = {1'b0, r_gt} - {1'b0, r_lt};
    assign w_tol    = {1'b0, ofs_tol_i};
    assign w_of_dn  = w_diff > w_tol;
    assign w_of_up  = w_diff < -w_tol;
    assign w_of_ext = {{2{r_offset[15]}}, r_offset};
    assign w_of_stp = {2'b00, offset_step_i};
    assign w_of_sum = w_of_ext + w_of_stp;
    assign w_of_dif = w_of_ext - w_of_stp;

    always_comb begin
        w_sc_new = r_scale;
        if (w_sc_dn)
            w_sc_new = (r_scale < scale_step_i) ? '0 : r_scale - scale_step_i;
        else if (w_sc_up)
            w_sc_new = w_sc_sum[17] ? 17'h1FFFF : w_sc_sum[16:0];
    end

    always_comb begin
        w_of_new = r_offset;
        if (w_of_dn)
            w_of_new = (w_of_dif < -18'sd32768) ? 16'h8000 : w_of_dif[15:0];
        else if (w_of_up)
            w_of_new = (w_of_sum > 18'sd32767) ? 16'h7FFF : w_of_sum[15:0];
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) r_state <= S_IDLE;
        else          r_state <= w_nxt;
    end

    always_comb begin
        w_nxt = r_state;
        if (r_state == S_IDLE) begin
            if (start_i && !stop_i) w_nxt = S_INIT_RST;
        end else if (w_halt || w_err || w_timeout) begin
            w_nxt = S_IDLE;
        end else begin
            unique case (r_state)
                S_INIT_RST: if (w_ack) w_nxt = S_INIT_SC;
                S_INIT_SC:  if (w_ack) w_nxt = S_INIT_OF;
                S_INIT_OF:  if (w_ack) w_nxt = S_INIT_LD;
                S_INIT_LD:  if (w_ack)
                    w_nxt = (iterations_i == '0) ? S_FINISH : S_TICK;
                S_TICK:     if (w_ack) w_nxt = S_POLL;
                S_POLL:     if (w_ack && w_done_bit) w_nxt = S_RD_SQ;
                S_RD_SQ:    if (w_ack) w_nxt = S_RD_GT;
                S_RD_GT:    if (w_ack) w_nxt = S_RD_LT;
                S_RD_LT:    if (w_ack) w_nxt = S_CALC;
                S_CALC:     w_nxt = S_WR_SC;
                S_WR_SC:    if (w_ack) w_nxt = S_WR_OF;
                S_WR_OF:    if (w_ack) w_nxt = S_WR_LD;
                S_WR_LD:    if (w_ack)
                    w_nxt = (r_conv || w_iter_nxt == iterations_i)
                            ? S_FINISH : S_TICK;
                S_FINISH:   w_nxt = S_IDLE;
                default:    w_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_we  = 1'b1;
        w_adr = 8'h00;
        w_dat = 32'h0;
        unique case (r_state)
            S_INIT_RST:         w_dat = 32'h4;
            S_INIT_SC, S_WR_SC: begin w_adr = 8'h10; w_dat = {15'h0, r_scale}; end
            S_INIT_OF, S_WR_OF: begin w_adr = 8'h14; w_dat = {16'h0, r_offset}; end
            S_INIT_LD, S_WR_LD: w_dat = 32'h700;
            S_TICK:             w_dat = 32'h1;
            S_POLL:             w_we  = 1'b0;
            S_RD_SQ:            begin w_we = 1'b0; w_adr = 8'h04; end
            S_RD_GT:            begin w_we = 1'b0; w_adr = 8'h08; end
            S_RD_LT:            begin w_we = 1'b0; w_adr = 8'h0C; end
            default:            w_we  = 1'b0;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_gap       <= 1'b0;
            r_stop_pend <= 1'b0;
            r_conv      <= 1'b0;
            r_converged <= 1'b0;
            r_error     <= 1'b0;
            r_poll      <= '0;
            r_sq        <= '0;
            r_gt        <= '0;
            r_lt        <= '0;
            r_scale     <= '0;
            r_offset    <= '0;
            r_iter      <= '0;
        end else begin
            r_gap <= w_xfer_end;
            if (r_state == S_IDLE) begin
                r_stop_pend <= 1'b0;
                if (w_nxt == S_INIT_RST) begin
                    r_scale     <= init_scale_i;
                    r_offset    <= init_offset_i;
                    r_iter      <= '0;
                    r_conv      <= 1'b0;
                    r_converged <= 1'b0;
                    r_error     <= 1'b0;
                end
            end else begin
                if (stop_i) r_stop_pend <= 1'b1;
                if (w_nxt == S_IDLE && r_state != S_FINISH) r_error <= 1'b1;
                if (r_state == S_FINISH) r_converged <= r_conv;
            end
            if (r_state == S_TICK) r_poll <= '0;
            if (r_state == S_POLL && w_ack && !w_done_bit) r_poll <= w_poll_nxt;
            if (r_state == S_RD_SQ && w_ack) r_sq <= m_wb.m_wb_dat_i[24:0];
            if (r_state == S_RD_GT && w_ack) r_gt <= m_wb.m_wb_dat_i[20:0];
            if (r_state == S_RD_LT && w_ack) r_lt <= m_wb.m_wb_dat_i[20:0];
            if (r_state == S_CALC) begin
                r_scale  <= w_sc_new;
                r_offset <= w_of_new;
                r_conv   <= (w_sc_new == r_scale) && (w_of_new == r_offset);
            end
            if (r_state == S_WR_LD && w_ack) r_iter <= w_iter_nxt;
        end
    end

    assign m_wb.m_wb_cyc_o = w_cyc;
    assign m_wb.m_wb_stb_o = w_cyc;
    assign m_wb.m_wb_we_o  = w_we;
    assign m_wb.m_wb_adr_o = w_adr;
    assign m_wb.m_wb_dat_o = w_dat;
    assign m_wb.m_wb_sel_o = 4'hF;

    assign busy_o      = (r_state != S_IDLE);
    assign done_o      = (r_state == S_FINISH);
    assign converged_o = r_converged;
    assign error_o     = r_error;
    assign scale_o     = r_scale;
    assign offset_o    = r_offset;
    assign iter_o      = r_iter;
endmodule

// File: tb/tb_agc_loop_sequencer.sv
// Scoreboard bench for agc_loop_sequencer: expected bus transactions
// are queued up front and a bus monitor pops and compares them.
module tb_agc_loop_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start, stop;
    logic [7:0]  iters;
    logic [24:0] target, sqtol;
    logic [20:0] otol;
    logic [16:0] sstep, iscale;
    logic [15:0] ostep, ioffset;
    logic        busy, done, conv, err;
    logic [16:0] scale;
    logic [15:0] offset;
    logic [7:0]  iter;

    agc_loop_sequencer_if bus ();

    agc_loop_sequencer #(.POLL_LIMIT(1024), .ITER_BITS(8)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .start_i(start), .stop_i(stop), .iterations_i(iters),
        .target_sq_i(target), .sq_tol_i(sqtol), .ofs_tol_i(otol),
        .scale_step_i(sstep), .offset_step_i(ostep),
        .init_scale_i(iscale), .init_offset_i(ioffset),
        .m_wb(bus),
        .busy_o(busy), .done_o(done), .converged_o(conv), .error_o(err),
        .scale_o(scale), .offset_o(offset), .iter_o(iter)
    );

    typedef struct packed {
        logic        we;
        logic [7:0]  adr;
        logic [31:0] dat;
    } txn_t;

    txn_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    // Register-block model: acks on the 3rd request cycle
    logic [24:0] sq_v;
    logic [20:0] gt_v, lt_v;
    bit          never_done = 1'b0;
    bit          err_arm = 1'b0;
    int          acnt, polls, w10;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.m_wb_ack_i <= 1'b0;
            bus.m_wb_err_i <= 1'b0;
            bus.m_wb_dat_i <= 32'h0;
            acnt  <= 0;
            polls <= 0;
            w10   <= 0;
        end else if (bus.m_wb_cyc_o && bus.m_wb_stb_o &&
                     !bus.m_wb_ack_i && !bus.m_wb_err_i) begin
            if (acnt == 2) begin
                acnt <= 0;
                if (err_arm && bus.m_wb_we_o && bus.m_wb_adr_o == 8'h10 && w10 == 1)
                    bus.m_wb_err_i <= 1'b1;
                else
                    bus.m_wb_ack_i <= 1'b1;
                if (bus.m_wb_we_o) begin
                    if (bus.m_wb_adr_o == 8'h00 && bus.m_wb_dat_o == 32'h4) w10 <= 0;
                    if (bus.m_wb_adr_o == 8'h00 && bus.m_wb_dat_o[0]) polls <= 0;
                    if (bus.m_wb_adr_o == 8'h10) w10 <= w10 + 1;
                end else begin
                    case (bus.m_wb_adr_o)
                        8'h00: begin
                            bus.m_wb_dat_i <= {30'h0, (!never_done && polls + 1 == 5), 1'b0};
                            polls <= polls + 1;
                        end
                        8'h04:   bus.m_wb_dat_i <= {7'h0, sq_v};
                        8'h08:   bus.m_wb_dat_i <= {11'h0, gt_v};
                        8'h0C:   bus.m_wb_dat_i <= {11'h0, lt_v};
                        default: bus.m_wb_dat_i <= 32'h0;
                    endcase
                end
            end else begin
                acnt <= acnt + 1;
            end
        end else begin
            bus.m_wb_ack_i <= 1'b0;
            bus.m_wb_err_i <= 1'b0;
        end
    end

    // Monitor: every slave response is matched against the queue head
    initial begin
        bit   pend;
        txn_t t, e;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (pend) chk("bus_idle_after_resp", 64'(bus.m_wb_cyc_o | bus.m_wb_stb_o), 64'h0);
            pend = 1'b0;
            if (!rst && bus.m_wb_cyc_o && bus.m_wb_stb_o &&
                (bus.m_wb_ack_i || bus.m_wb_err_i)) begin
                pend = 1'b1;
                t.we  = bus.m_wb_we_o;
                t.adr = bus.m_wb_adr_o;
                t.dat = bus.m_wb_we_o ? bus.m_wb_dat_o : 32'h0;
                chk("sel", 64'(bus.m_wb_sel_o), 64'hF);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_txn: got %0h, want none", t);
                end else begin
                    e = exp_q.pop_front();
                    chk("txn", 64'(t), 64'(e));
                end
            end
        end
    end

    task automatic pw(input logic [7:0] a, input logic [31:0] d);
        exp_q.push_back('{we: 1'b1, adr: a, dat: d});
    endtask

    task automatic pr(input logic [7:0] a);
        exp_q.push_back('{we: 1'b0, adr: a, dat: 32'h0});
    endtask

    task automatic push_init(input logic [16:0] sc, input logic [15:0] of);
        pw(8'h00, 32'h4);
        pw(8'h10, {15'h0, sc});
        pw(8'h14, {16'h0, of});
        pw(8'h00, 32'h700);
    endtask

    task automatic push_reads(input int npoll);
        pw(8'h00, 32'h1);
        for (int i = 0; i < npoll; i++) pr(8'h00);
        pr(8'h04);
        pr(8'h08);
        pr(8'h0C);
    endtask

    task automatic push_wr(input logic [16:0] sc, input logic [15:0] of);
        pw(8'h10, {15'h0, sc});
        pw(8'h14, {16'h0, of});
        pw(8'h00, 32'h700);
    endtask

    // Pulse start, wait (bounded) for the run to end, count done pulses
    task automatic run(output int dn);
        int n;
        dn = 0;
        n  = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (busy && n < 20000) begin
            if (done) dn++;
            @(negedge clk);
            n++;
        end
        chk("run_ends", 64'(busy), 64'h0);
        repeat (3) @(negedge clk);
        chk("exp_drained", 64'(exp_q.size()), 64'h0);
    endtask

    task automatic wait_req(input logic [7:0] a);
        int n;
        n = 0;
        while (!(bus.m_wb_cyc_o && bus.m_wb_adr_o == a && !bus.m_wb_ack_i) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen", 64'(bus.m_wb_cyc_o), 64'h1);
    endtask

    initial begin
        int dn;
        start = 0; stop = 0; iters = 8'd2;
        target = 25'h0100000; sqtol = 25'h1000; otol = 21'h10;
        sstep = 17'h400; ostep = 16'h10;
        iscale = 17'h08000; ioffset = 16'h0;
        sq_v = 25'h0200000; gt_v = 21'h100; lt_v = 21'h100;

        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_cyc", 64'(bus.m_wb_cyc_o), 64'h0);
        chk("rst_flags", 64'({done, conv, err}), 64'h0);
        chk("rst_scale", 64'(scale), 64'h0);
        chk("rst_offset", 64'(offset), 64'h0);
        chk("rst_iter", 64'(iter), 64'h0);
        rst = 1'b0;
        @(negedge clk);

        // Two iterations, scale stepping down
        push_init(17'h08000, 16'h0);
        push_reads(5); push_wr(17'h07C00, 16'h0);
        push_reads(5); push_wr(17'h07800, 16'h0);
        run(dn);
        chk("t1_done", 64'(dn), 64'h1);
        chk("t1_iter", 64'(iter), 64'h2);
        chk("t1_scale", 64'(scale), 64'h07800);
        chk("t1_conv_err", 64'({conv, err}), 64'h0);

        // Inside both deadbands on the first iteration
        iters = 8'd10; sq_v = 25'h0100800;
        push_init(17'h08000, 16'h0);
        push_reads(5); push_wr(17'h08000, 16'h0);
        run(dn);
        chk("t2_done", 64'(dn), 64'h1);
        chk("t2_conv", 64'(conv), 64'h1);
        chk("t2_iter", 64'(iter), 64'h1);
        chk("t2_scale", 64'(scale), 64'h08000);

        // Saturation of scale and offset
        iters = 8'd1; iscale = 17'h1FF00; ioffset = 16'h7FFE;
        sq_v = 25'h10; gt_v = 21'h0; lt_v = 21'h1000;
        push_init(17'h1FF00, 16'h7FFE);
        push_reads(5); push_wr(17'h1FFFF, 16'h7FFF);
        run(dn);
        chk("t3_scale", 64'(scale), 64'h1FFFF);
        chk("t3_offset", 64'(offset), 64'h7FFF);
        chk("t3_conv", 64'(conv), 64'h0);
        chk("t3_iter", 64'(iter), 64'h1);

        // Done bit never set -> poll timeout
        iscale = 17'h08000; ioffset = 16'h0; never_done = 1'b1;
        push_init(17'h08000, 16'h0);
        pw(8'h00, 32'h1);
        for (int i = 0; i < 1024; i++) pr(8'h00);
        run(dn);
        never_done = 1'b0;
        chk("t4_done", 64'(dn), 64'h0);
        chk("t4_err", 64'(err), 64'h1);
        chk("t4_iter", 64'(iter), 64'h0);

        // Bus error on the loop's scale write, then a clean run
        sq_v = 25'h0100800; gt_v = 21'h100; lt_v = 21'h100; err_arm = 1'b1;
        push_init(17'h08000, 16'h0);
        push_reads(5); pw(8'h10, 32'h08000);
        run(dn);
        err_arm = 1'b0;
        chk("t5_done", 64'(dn), 64'h0);
        chk("t5_err", 64'(err), 64'h1);
        push_init(17'h08000, 16'h0);
        push_reads(5); push_wr(17'h08000, 16'h0);
        run(dn);
        chk("t5b_done", 64'(dn), 64'h1);
        chk("t5b_err_conv", 64'({err, conv}), 64'h1);

        // Stop while the sq read waits for ack
        sq_v = 25'h0200000; iters = 8'd2;
        push_init(17'h08000, 16'h0);
        push_reads(5);
        exp_q.pop_back(); exp_q.pop_back();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_req(8'h04);
        stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        for (int n = 0; n < 200 && busy; n++) @(negedge clk);
        chk("t6_busy", 64'(busy), 64'h0);
        chk("t6_err", 64'(err), 64'h1);
        repeat (3) @(negedge clk);
        chk("t6_drained", 64'(exp_q.size()), 64'h0);

        // Start with stop in IDLE: stop wins
        start = 1'b1; stop = 1'b1;
        @(negedge clk); start = 1'b0; stop = 1'b0;
        repeat (10) @(negedge clk);
        chk("t7_busy", 64'(busy), 64'h0);
        chk("t7_err", 64'(err), 64'h1);

        // Async reset mid-transaction
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_req(8'h00);
        #2 rst = 1'b1;
        #1;
        chk("t8_cyc", 64'({bus.m_wb_cyc_o, bus.m_wb_stb_o}), 64'h0);
        chk("t8_busy", 64'(busy), 64'h0);
        chk("t8_scale", 64'(scale), 64'h0);
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/agc_loop_sequencer.md
Name: agc_loop_sequencer

Overview:
- Autonomous Wishbone master that closes the AGC gain/offset loop for one channel's AGC register block.
- Sequence: init the AGC, then per iteration: tick, poll for done, read the accumulators, compute a new scale/offset, load and apply.
- Sits in the wb_clk_i domain between the housekeeping CPU (start/configure) and the AGC register block (slave).

Parameters:
- POLL_LIMIT, 1024: maximum done-poll reads before timeout.
- ITER_BITS, 8: width of the iteration count and counter.

Ports:
- wb_clk_i  in  1  Wishbone/system clock; only clock.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  pulse: begin a run (ignored while busy).
- stop_i  in  1  pulse: abort after the current bus transaction.
- iterations_i  in  ITER_BITS  iterations per run; 0 means init only.
- target_sq_i  in  25  desired square accumulator.
- sq_tol_i  in  25  square deadband.
- ofs_tol_i  in  21  gt/lt imbalance deadband.
- scale_step_i  in  17  scale increment.
- offset_step_i  in  16  offset increment.
- init_scale_i  in  17  starting scale.
- init_offset_i  in  16  starting offset, signed.
- m_wb_cyc_o, m_wb_stb_o, m_wb_we_o  out  1  master strobes.
- m_wb_adr_o  out  8  byte address.
- m_wb_dat_o  out  32  write data.
- m_wb_sel_o  out  4  byte selects; always 4'hF.
- m_wb_dat_i  in  32  read data.
- m_wb_ack_i, m_wb_err_i  in  1  slave responses.
- busy_o  out  1  run in progress.
- done_o  out  1  one-cycle pulse at normal run end.
- converged_o  out  1  sticky: last run ended inside both deadbands.
- error_o  out  1  sticky: last run ended on err, timeout or stop.
- scale_o  out  17  current scale.
- offset_o  out  16  current offset.
- iter_o  out  ITER_BITS  completed iterations.

Behaviour:
- Reset values:
  - All outputs 0.
  - scale_o = 0, offset_o = 0.
  - FSM in IDLE.
- Slave register map:
  - 0x00 control: bit0 tick, bit1 done (read), bit2 reset, bit8 load scale, bit9 load offset, bit10 apply.
  - 0x04 sq[24:0], 0x08 gt[20:0], 0x0C lt[20:0].
  - 0x10 scale[16:0], 0x14 offset[15:0].
- Bus rules:
  - Entering a bus state asserts cyc, stb, adr, we, dat together and holds them until the cycle ack_i or err_i is sampled high.
  - cyc/stb drop the following cycle.
  - At least one idle cycle between transactions.
  - err_i: abort, set error_o, go IDLE.
- Transition out of IDLE:
  - IDLE -> INIT on start_i with stop_i low.
  - start_i and stop_i in the same cycle: stop wins.
  - On leaving IDLE: clear converged_o, error_o and iter_o; load scale_o/offset_o from init_*_i; assert busy_o.
- Init sequence:
  - INIT_RST: write 0x00 = 0x4.
  - INIT_SC: write 0x10 = scale_o.
  - INIT_OF: write 0x14 = offset_o, zero-extended.
  - INIT_LD: write 0x00 = 0x700.
  - If iterations_i = 0 -> FINISH, else TICK.
- Per-iteration loop:
  - TICK: write 0x00 = 0x1; reset poll counter.
  - POLL: read 0x00.
    - bit1 set -> RD_SQ.
    - Otherwise increment the poll counter and re-read.
    - Counter reaching POLL_LIMIT -> error_o, IDLE.
  - RD_SQ, RD_GT, RD_LT: latch the respective fields.
  - CALC: one cycle, see the rules below.
  - WR_SC, WR_OF, WR_LD: same writes as INIT_SC, INIT_OF, INIT_LD; then iter_o += 1.
  - If converged, or iter_o equals iterations_i -> FINISH, else TICK.
- CALC rules:
  - Scale down when sq > target + sq_tol, using a 26-bit sum.
  - Scale up when sq < target - sq_tol; a negative lower bound is treated as 0.
  - Scale saturates to the range 0..0x1FFFF.
  - diff = gt - lt, 22-bit signed.
  - Offset down when diff > ofs_tol; offset up when diff < -ofs_tol.
  - Offset saturates signed to 0x8000..0x7FFF.
  - Converged when neither scale nor offset changes; that iteration's writes still occur.
- FINISH: pulse done_o, set converged_o if applicable, clear busy_o, go IDLE.
- Stop and restart:
  - stop_i while busy: complete the outstanding transaction (not aborted mid-handshake), then set error_o, go IDLE; no done_o.
  - start_i while busy: ignored.
  - Async reset mid-transaction drops cyc/stb immediately.

Test Plan:
- Slave model acks in 3 cycles and asserts done on the 5th poll; init 0x08000/0x0000, iterations_i = 2, sq read 0x0200000 > target 0x0100000 + tol 0x1000 with scale_step_i = 0x400, gt = lt -> writes 0x4, 0x10 = 0x08000, 0x14 = 0, 0x700, 0x1; first loop writes scale 0x07C00, second 0x07800; done_o pulses once; iter_o = 2; converged_o = 0.
- sq within deadband and gt = lt on the first iteration, iterations_i = 10 -> converged_o = 1, iter_o = 1, done_o pulses, scale unchanged.
- init_scale_i = 0x1FF00, step 0x400, sq below target -> scale saturates at 0x1FFFF; init_offset_i = 0x7FFE, lt ≫ gt, step 0x10 -> offset saturates at 0x7FFF.
- Done bit never set -> exactly 1024 poll reads, then error_o = 1, busy_o = 0, no done_o.
- err_i during WR_SC -> cyc drops the next cycle, error_o = 1; a following start_i runs a full run normally.
- stop_i while a read waits for ack -> the transaction completes, then IDLE with error_o = 1; start_i asserted with stop_i in IDLE -> no run starts.
